// File: rtl/fetch_unit_if.sv
// Instruction-memory request/grant/response bus between the fetch stage and imem.
// The fetch stage is the master: it drives the request and address, and memory answers.
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the architectural PC, fetches one instruction per retire over the
// imem handshake, and counts retired instructions. Misaligned targets stop fetch until reset.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   fetch_unit_if.master  imem,
   input  logic [31:0]   i_pc_next,
   input  logic          i_retire,
   output logic [31:0]   o_pc,
   output logic [31:0]   o_instr,
   output logic          o_instr_valid,
   output logic          o_fetch_fault,
   output logic [31:0]   o_instret
);

   typedef enum logic [2:0] {
      S_BOOT  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_pc;
   logic [31:0] w_pc_next;
   logic [31:0] r_instr;
   logic [31:0] w_instr_next;
   logic [31:0] r_instret;
   logic [31:0] w_instret_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_BOOT;
         r_pc      <= RESET_PC;
         r_instr   <= 32'h0000_0000;
         r_instret <= 32'h0000_0000;
      end else begin
         r_state   <= w_state_next;
         r_pc      <= w_pc_next;
         r_instr   <= w_instr_next;
         r_instret <= w_instret_next;
      end
   end

   // Retire and rvalid are each honoured in exactly one state, so they never collide.
   always_comb begin
      w_state_next   = r_state;
      w_pc_next      = r_pc;
      w_instr_next   = r_instr;
      w_instret_next = r_instret;
      case (r_state)
         S_BOOT: w_state_next = S_REQ;
         S_REQ: begin
            if (imem.imem_gnt) begin
               w_state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem.imem_rvalid) begin
               w_instr_next = imem.imem_rdata;
               w_state_next = S_HOLD;
            end
         end
         S_HOLD: begin
            if (i_retire) begin
               w_pc_next      = i_pc_next;
               w_instret_next = r_instret + 32'd1;
               w_state_next   = (i_pc_next[1:0] == 2'b00) ? S_REQ : S_FAULT;
            end
         end
         S_FAULT: w_state_next = S_FAULT;
         default: w_state_next = S_BOOT;
      endcase
   end

   // All outputs come straight from registers: no input-to-output combinational path.
   assign imem.imem_req  = (r_state == S_REQ);
   assign imem.imem_addr = r_pc;
   assign o_pc           = r_pc;
   assign o_instr        = r_instr;
   assign o_instr_valid  = (r_state == S_HOLD);
   assign o_fetch_fault  = (r_state == S_FAULT);
   assign o_instret      = r_instret;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: the bench plays instruction memory and the core,
// and checks against a transaction-level model of PC, retire count and fault.
module tb_fetch_unit;
   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc_next = 32'h0;
   logic        retire = 1'b0;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        instr_valid;
   logic        fetch_fault;
   logic [31:0] instret;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem          (bus),
      .i_pc_next     (pc_next),
      .i_retire      (retire),
      .o_pc          (pc),
      .o_instr       (instr),
      .o_instr_valid (instr_valid),
      .o_fetch_fault (fetch_fault),
      .o_instret     (instret)
   );

   always #5 clk = ~clk;

   int n_run  = 0;
   int n_fail = 0;

   // Reference model: architectural PC and retired count at transaction level.
   logic [31:0] m_pc;
   logic [31:0] m_instret;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_reset_vals(input string ctx);
      check({ctx, "_req"},     32'(bus.imem_req), 32'd0);
      check({ctx, "_fault"},   32'(fetch_fault),  32'd0);
      check({ctx, "_valid"},   32'(instr_valid),  32'd0);
      check({ctx, "_pc"},      pc,                RST_PC);
      check({ctx, "_instr"},   instr,             32'h0);
      check({ctx, "_instret"}, instret,           32'h0);
   endtask

   // Entered at a negedge where a request is expected; leaves the DUT holding the word.
   task automatic fetch(input int gnt_dly, input int rv_dly, input logic [31:0] word,
                        input bit spur);
      check("req", 32'(bus.imem_req), 32'd1);
      check("addr", bus.imem_addr, m_pc);
      for (int i = 0; i < gnt_dly; i++) begin
         bus.imem_gnt    = 1'b0;
         bus.imem_rvalid = 1'($urandom_range(0, 1));
         bus.imem_rdata  = $urandom;
         tick();
         check("stall_req", 32'(bus.imem_req), 32'd1);
         check("stall_addr", bus.imem_addr, m_pc);
         check("stall_valid", 32'(instr_valid), 32'd0);
      end
      bus.imem_gnt    = 1'b1;
      bus.imem_rvalid = 1'($urandom_range(0, 1));
      bus.imem_rdata  = $urandom;
      tick();
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      check("wait_req", 32'(bus.imem_req), 32'd0);
      for (int i = 0; i < rv_dly; i++) begin
         retire  = spur;
         pc_next = $urandom;
         tick();
         retire  = 1'b0;
         check("wait_valid", 32'(instr_valid), 32'd0);
         check("wait_pc", pc, m_pc);
         check("wait_instret", instret, m_instret);
      end
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = word;
      tick();
      bus.imem_rvalid = 1'b0;
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_instr", instr, word);
      check("hold_pc", pc, m_pc);
      check("hold_req", 32'(bus.imem_req), 32'd0);
      $display("[TB] fetch pc=%h instr=%h gnt_dly=%0d rv_dly=%0d instret=%0d",
               pc, instr, gnt_dly, rv_dly, instret);
      for (int i = 0; i < 2; i++) begin
         bus.imem_rvalid = 1'($urandom_range(0, 1));
         bus.imem_rdata  = $urandom;
         tick();
         check("hold_keep_instr", instr, word);
         check("hold_keep_valid", 32'(instr_valid), 32'd1);
      end
      bus.imem_rvalid = 1'b0;
   endtask

   task automatic do_retire(input logic [31:0] target);
      pc_next = target;
      retire  = 1'b1;
      tick();
      retire  = 1'b0;
      m_instret = m_instret + 32'd1;
      m_pc      = target;
      check("ret_instret", instret, m_instret);
      check("ret_pc", pc, m_pc);
      check("ret_valid", 32'(instr_valid), 32'd0);
      if (target[1:0] != 2'b00) begin
         check("ret_fault", 32'(fetch_fault), 32'd1);
         check("ret_req_off", 32'(bus.imem_req), 32'd0);
      end else begin
         check("ret_req", 32'(bus.imem_req), 32'd1);
         check("ret_addr", bus.imem_addr, target);
         check("ret_nofault", 32'(fetch_fault), 32'd0);
      end
      $display("[TB] retire pc_next=%h instret=%0d fault=%0b", target, instret, fetch_fault);
   endtask

   task automatic assert_reset_midcycle(input string ctx);
      #2 rst_n = 1'b0;
      #1 check_reset_vals(ctx);
      m_pc      = RST_PC;
      m_instret = 32'h0;
      tick();
   endtask

   initial begin
      logic [31:0] tgt;
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      m_pc      = RST_PC;
      m_instret = 32'h0;

      // Power-on reset, then the BOOT cycle before the first request.
      repeat (3) tick();
      check_reset_vals("por");
      rst_n = 1'b1;
      #1 check("boot_req", 32'(bus.imem_req), 32'd0);
      tick();

      // Zero-wait fetch and aligned retire.
      fetch(0, 0, 32'h0050_0093, 1'b0);
      do_retire(32'h0000_0104);

      // Grant stall with ignored rvalid pulses and spurious retires in WAIT.
      fetch(5, 2, $urandom, 1'b1);
      tgt = $urandom;
      do_retire({tgt[31:2], 2'b00});

      for (int n = 0; n < 20; n++) begin
         fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
               1'($urandom_range(0, 1)));
         tgt = $urandom;
         do_retire({tgt[31:2], 2'b00});
      end

      // Counter wrap from a preloaded all-ones count.
      fetch(1, 1, $urandom, 1'b0);
      force dut.r_instret = 32'hFFFF_FFFF;
      tick();
      release dut.r_instret;
      m_instret = 32'hFFFF_FFFF;
      check("instret_preload", instret, m_instret);
      do_retire(32'h0000_2000);
      check("instret_wrap", instret, 32'h0);

      // Misaligned target: sticky fault, further retires ignored, reset clears it.
      fetch(0, 1, $urandom, 1'b0);
      do_retire(32'h0000_0106);
      for (int i = 0; i < 4; i++) begin
         retire          = 1'b1;
         pc_next         = $urandom;
         bus.imem_gnt    = 1'($urandom_range(0, 1));
         bus.imem_rvalid = 1'($urandom_range(0, 1));
         tick();
         retire          = 1'b0;
         check("fault_sticky", 32'(fetch_fault), 32'd1);
         check("fault_req", 32'(bus.imem_req), 32'd0);
         check("fault_valid", 32'(instr_valid), 32'd0);
         check("fault_pc", pc, 32'h0000_0106);
         check("fault_instret", instret, m_instret);
      end
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      assert_reset_midcycle("fault_rst");
      rst_n = 1'b1;
      tick();
      fetch(0, 0, 32'h0000_0013, 1'b0);
      do_retire(32'h0000_0108);

      // Spurious retire in WAIT, then reset in WAIT with a late response.
      bus.imem_gnt = 1'b1;
      tick();
      bus.imem_gnt = 1'b0;
      retire  = 1'b1;
      pc_next = 32'h0000_4000;
      tick();
      retire  = 1'b0;
      check("spur_pc", pc, m_pc);
      check("spur_instret", instret, m_instret);
      check("spur_valid", 32'(instr_valid), 32'd0);
      assert_reset_midcycle("wait_rst");
      rst_n           = 1'b1;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
      tick();
      check("late_instr", instr, 32'h0);
      check("late_valid", 32'(instr_valid), 32'd0);
      tick();
      bus.imem_rvalid = 1'b0;
      check("late_instr2", instr, 32'h0);
      fetch(2, 1, 32'h00A0_0113, 1'b0);
      do_retire(32'h0000_0110);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle RISC-V core. Holds the architectural program counter, fetches the instruction at that address from instruction memory over a request/grant/response handshake, and presents the instruction and its PC to decode and to the next-PC logic. When the core retires the current instruction, the block loads the next-PC value produced by the PC control block and starts the next fetch.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pc_next  in  32  next PC from the PC control block, sampled on retire
- retire  in  1  current instruction completes this cycle
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, equal to pc while imem_req=1
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction word
- pc  out  32  PC of the instruction on instr
- instr  out  32  fetched instruction
- instr_valid  out  1  instr/pc hold a valid, unretired instruction
- fetch_fault  out  1  sticky misaligned-target fault
- instret  out  32  retired-instruction counter

## Operation
- States: BOOT, REQ, WAIT, HOLD, FAULT. Reset state BOOT.
- BOOT: no request; next cycle unconditionally -> REQ.
- REQ: imem_req=1, imem_addr=pc. imem_gnt=1 -> WAIT; else remain in REQ with address stable. imem_rvalid ignored in REQ.
- WAIT: imem_req=0. imem_rvalid=1 -> instr<=imem_rdata, instr_valid<=1, -> HOLD. Otherwise remain.
- HOLD: instr_valid=1, instr and pc stable. retire=1 -> pc<=pc_next, instr_valid<=0, instret<=instret+1; if pc_next[1:0]==0 -> REQ, else -> FAULT.
- FAULT: fetch_fault=1, imem_req=0, instr_valid=0; pc holds the faulting pc_next. Exit only via reset.
- retire while instr_valid=0 (BOOT/REQ/WAIT/FAULT): ignored; pc and instret unchanged.
- instret: 32-bit, wraps 32'hFFFF_FFFF -> 0.
- imem_req, fetch_fault, instr_valid decoded from registered state only; no combinational path from any input to any output.
- instr retains last captured word while instr_valid=0; value is don't-care for consumers.

## Timing
- Reset (rst_n=0, asynchronous): state=BOOT, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_fault=0, instret=0. Outputs take these values immediately on rst_n fall, independent of clk.
- First imem_req=1 in the second rising edge after rst_n release (BOOT occupies one cycle).
- Handshake: request transfers on edge where imem_req=1 and imem_gnt=1; imem_addr must not change while imem_req=1 and gnt=0. Memory returns exactly one rvalid per grant, earliest the cycle after grant.
- Retire-to-refetch: retire at edge t -> imem_req=1 in cycle t+1. With gnt same cycle and rvalid next cycle, instr_valid=1 at cycle t+3 (minimum 3-cycle turnaround).
- Reset mid-fetch (REQ or WAIT): outstanding response discarded; any rvalid before the new grant after reset is ignored (block is in BOOT/REQ).
- Simultaneous retire and rvalid: impossible by state (rvalid only honoured in WAIT, retire only in HOLD); rvalid in HOLD ignored.

## Test plan
- Reset with RESET_PC=32'h0000_0100: during rst_n=0 all outputs at reset values; after release imem_req=1 on second edge with imem_addr=32'h100.
- Zero-wait fetch: gnt with req, rvalid next cycle with rdata=32'h0050_0093 -> instr=32'h0050_0093, pc=32'h100, instr_valid=1; retire with pc_next=32'h104 -> next imem_addr=32'h104, instret=1.
- Grant stall: hold imem_gnt=0 for 5 cycles -> imem_req stays 1, imem_addr stable; rvalid pulses during REQ ignored.
- Misaligned target: retire with pc_next=32'h0000_0106 -> fetch_fault=1, imem_req=0 forever, pc=32'h106; further retire pulses leave instret unchanged; rst_n clears fault.
- Spurious retire in WAIT and reset asserted in WAIT: pc/instret unchanged; after reset, fetch restarts at RESET_PC and late rvalid is not captured.
- Counter wrap: preload via 2^32 retires in sim (or force instret=32'hFFFF_FFFF) then retire -> instret=0.
